shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 114 +++++++++++
 tb/tb_shift_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle sequencer driving a 4-bit combinational shifter
// Owns the operand register; applies the latched op count times, then pulses done.
module shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [CNT_W-1:0] count,
   input  logic [WIDTH-1:0] din,
   output logic [1:0]       sh_sel,
   output logic [WIDTH-1:0] sh_in,
   input  logic [WIDTH-1:0] sh_out,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_ZERO = '0;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_rem;
   logic [1:0]       r_op;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Datapath: load on accepted start, write back shifter result each SHIFT cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data <= '0;
         r_rem  <= '0;
         r_op   <= 2'b00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_data <= din;
                  r_op   <= op;
                  r_rem  <= count;
               end
            end
            ST_SHIFT: begin
               r_data <= sh_out;
               r_rem  <= r_rem - C_ONE;
            end
            default: begin
               r_data <= r_data;
            end
         endcase
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = (count != C_ZERO) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (r_rem == C_ONE) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Moore outputs: decoded from registered state only, so start never reaches sh_sel
   always_comb begin
      sh_sel = 2'b00;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         ST_SHIFT: begin
            sh_sel = r_op;
            busy   = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            sh_sel = 2'b00;
         end
      endcase
   end

   assign sh_in = r_data;
   assign dout  = r_data;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer with a 4-bit shifter model
// Directed plan steps followed by random commands checked against an arithmetic reference.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] op;
   logic [2:0] count;
   logic [3:0] din;
   logic [1:0] sh_sel;
   logic [3:0] sh_in;
   logic [3:0] sh_out;
   logic [3:0] dout;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .count  (count),
      .din    (din),
      .sh_sel (sh_sel),
      .sh_in  (sh_in),
      .sh_out (sh_out),
      .dout   (dout),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   // 4-bit shifter: left/right fill with 0, rotate is rotate-left
   always_comb begin
      sh_out = sh_in;
      case (sh_sel)
         2'b01:   sh_out = {sh_in[2:0], 1'b0};
         2'b10:   sh_out = {1'b0, sh_in[3:1]};
         2'b11:   sh_out = {sh_in[2:0], sh_in[3]};
         default: sh_out = sh_in;
      endcase
   end

   function automatic logic [3:0] ref_step(input logic [1:0] f_op, input logic [3:0] f_x);
      int v;
      v = int'(f_x);
      case (f_op)
         2'b01:   v = (v * 2) % 16;
         2'b10:   v = v / 2;
         2'b11:   v = (v * 2) % 16 + v / 8;
         default: v = v;
      endcase
      return 4'(v);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one command from IDLE and checks every cycle until back in IDLE
   task automatic run_cmd(input logic [1:0] c_op, input logic [2:0] c_cnt, input logic [3:0] c_din);
      logic [3:0] exp_v;
      exp_v = c_din;
      start = 1'b1;
      op    = c_op;
      count = c_cnt;
      din   = c_din;
      tick();
      start = 1'b0;
      op    = 2'($urandom);
      count = 3'($urandom);
      din   = 4'($urandom);
      for (int k = 0; k < int'(c_cnt); k++) begin
         check("shift_busy", 32'(busy), 32'd1);
         check("shift_sel", 32'(sh_sel), 32'(c_op));
         check("shift_done", 32'(done), 32'd0);
         check("shift_dout", 32'(dout), 32'(exp_v));
         exp_v = ref_step(c_op, exp_v);
         tick();
      end
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_sel", 32'(sh_sel), 32'd0);
      check("done_dout", 32'(dout), 32'(exp_v));
      check("done_shin", 32'(sh_in), 32'(exp_v));
      start = 1'b1;
      din   = ~exp_v;
      tick();
      start = 1'b0;
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_hold", 32'(dout), 32'(exp_v));
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b1;
      op    = 2'b01;
      count = 3'd3;
      din   = 4'b1111;
      tick();
      tick();
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sel", 32'(sh_sel), 32'd0);
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      check("post_rst_idle", 32'(busy), 32'd0);

      run_cmd(2'b01, 3'd1, 4'b1001);
      check("shl_final", 32'(dout), 32'b0010);
      run_cmd(2'b10, 3'd2, 4'b1001);
      check("shr_final", 32'(dout), 32'b0010);
      run_cmd(2'b11, 3'd3, 4'b1100);
      check("rot_final", 32'(dout), 32'b0110);
      run_cmd(2'b00, 3'd5, 4'b1011);
      check("hold_final", 32'(dout), 32'b1011);
      run_cmd(2'b00, 3'd0, 4'b0110);
      check("zero_final", 32'(dout), 32'b0110);

      // Busy start ignored, then reset at the third shift edge
      start = 1'b1;
      op    = 2'b01;
      count = 3'd7;
      din   = 4'b0001;
      tick();
      start = 1'b0;
      tick();
      check("br_e1", 32'(dout), 32'b0010);
      start = 1'b1;
      din   = 4'b1111;
      op    = 2'b10;
      tick();
      start = 1'b0;
      check("br_ignored", 32'(dout), 32'b0100);
      check("br_busy", 32'(busy), 32'd1);
      check("br_sel", 32'(sh_sel), 32'b01);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("br_rst_dout", 32'(dout), 32'h0);
      check("br_rst_busy", 32'(busy), 32'd0);
      check("br_rst_done", 32'(done), 32'd0);
      check("br_rst_sel", 32'(sh_sel), 32'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("br_no_done", 32'(done), 32'd0);
      end

      for (int n = 0; n < 25; n++) begin
         run_cmd(2'($urandom), 3'($urandom), 4'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
